counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Controller for a wrapping mod-N up/down counter; the counter lives inside this block.
- On a start request it latches a target and a direction policy, then steps the counter one position per step slot until count equals target.
- Pulses done on arrival; abort cancels a run.
- Used wherever a position, index or channel pointer must walk to a commanded value on a ring of N positions.

Parameters:
- N, 10, ring modulus; count range 0..N-1; N >= 2.
- W, $clog2(N), localparam; width of count and target.
- DIV, 4, step prescale divisor, DIV >= 1; used only with STEP_PRESCALE_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- target  in  W  destination count; sampled with start
- dir_mode  in  2  00 up, 01 down, 10 shortest path, 11 treated as 10
- abort  in  1  cancel the current run
- count  out  W  current counter value
- up  out  1  latched step direction (1 = up)
- step_en  out  1  high in cycles where count changes on the next edge
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, in the DONE state
- err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset, rst low at a clock edge: state IDLE, count=0, up=1, step_en=0, busy=0, done=0, err=0. Reset wins over every other input, including mid-run; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=0:
  - count holds; all pulses low.
- IDLE, start=1 and target >= N:
  - err=1 for the next cycle; stay in IDLE; nothing latched.
- IDLE, start=1 and target < N:
  - Latch target.
  - Latch direction:
    - dir_mode 00: up=1.
    - dir_mode 01: up=0.
    - dir_mode 10/11: du=(target-count) mod N, dd=(count-target) mod N; up=1 if du<=dd (a tie goes up), else up=0.
  - If target==count: go to DONE (zero steps). Otherwise go to RUN.
- RUN, each step slot (every cycle without the optional feature):
  - Up: count <= (count==N-1) ? 0 : count+1.
  - Down: count <= (count==0) ? N-1 : count-1.
  - If the stepped value equals the latched target, go to DONE on the same edge.
  - Latency: d steps finish in d edges after the accepting edge; done is high in the cycle after the final step.
- step_en: combinational; high in RUN when the current cycle is a step slot.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - A start present in the DONE cycle is ignored; it must be re-presented in IDLE.
- abort:
  - In RUN: go to IDLE on the next edge; count holds its current value with no step on that edge; no done.
  - In DONE: ignored.
  - In IDLE: no effect.
- start, target and dir_mode are ignored while busy=1.
- Arithmetic: distance computations are done at W+1 bits to avoid wrap errors when N is not a power of two; count never takes a value >= N.

Optional Feature:
- Macro: STEP_PRESCALE_EN.
- Defined:
  - A prescale counter 0..DIV-1 clears on the accepting edge.
  - A step slot occurs when the prescale counter reaches DIV-1.
  - d steps take d*DIV edges after acceptance.
  - step_en is high only in step-slot cycles.
  - abort and reset also clear the prescale counter.
- Undefined:
  - No prescale logic; every RUN cycle is a step slot; DIV is unused.

Test Plan:
- N=10, count=0, start target=3, dir_mode=00 -> count 1,2,3 on three consecutive edges; done high one cycle after count=3; busy high 4 cycles.
- count=2, target=8, dir_mode=01 -> sequence 1,0,9,8 (wrap 0->9); up=0; done after 4 steps.
- Shortest path:
  - count=1, target=8, dir_mode=10 -> up=0, sequence 0,9,8.
  - count=0, target=5 -> tie, up=1, sequence 1..5.
- Rejected and zero-length starts:
  - start with target=12 -> err one cycle; state stays IDLE; count unchanged.
  - start with target==count -> done the next cycle with no count change.
- Abort and reset mid-run:
  - count=0, target=7 up; abort asserted when count=4 -> IDLE next edge; count stays 4; no done.
  - rst=0 mid-run -> count=0, busy=0 next edge.
- With STEP_PRESCALE_EN and DIV=4: count=0, target=2 up -> count changes only every 4th edge (edges 4 and 8 after acceptance); step_en high only in those slot cycles.

Source files
------------

// File: rtl/counter_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : counter_sequencer                                            |
// | Description : Walks an internal wrapping mod-N counter to a commanded       |
// |               target (up, down or shortest path). Optional step prescaler   |
// |               is enabled by defining STEP_PRESCALE_EN.                      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module counter_sequencer #(
    parameter int  N   = 10,
    parameter int  DIV = 4,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] target,
    input  logic [1:0]   dir_mode,
    input  logic         abort,
    output logic [W-1:0] count,
    output logic         up,
    output logic         step_en,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int         c_LAST_I = N - 1;
    localparam logic [W:0] c_N      = N[W:0];
    localparam logic [W-1:0] c_LAST = c_LAST_I[W-1:0];

    logic [1:0]   r_state, w_state_nxt;
    logic [W-1:0] r_count, w_count_nxt;
    logic [W-1:0] r_target, w_target_nxt;
    logic [W-1:0] w_step_val;
    logic         r_up, w_up_nxt;
    logic         r_err, w_err_nxt;
    logic         w_accept;
    logic         w_slot;
    logic [W:0]   w_tgt_ext, w_cnt_ext, w_du, w_dd;

`ifdef STEP_PRESCALE_EN
    localparam int            c_PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int            c_PRE_LAST_I = DIV - 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PRE_LAST_I[c_PW-1:0];

    logic [c_PW-1:0] r_pre;

    // Free-runs only while RUN; any exit from RUN or a new acceptance restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (w_accept || (r_state != S_RUN) || abort) begin
            r_pre <= '0;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_slot = (r_pre == c_PRE_LAST);
`else
    logic w_unused_div;
    assign w_unused_div = (DIV < 1);
    assign w_slot       = 1'b1;
`endif

    // Widened operands keep the modular distance exact for non power-of-two N.
    assign w_tgt_ext = {1'b0, target};
    assign w_cnt_ext = {1'b0, r_count};
    assign w_du = (w_tgt_ext >= w_cnt_ext) ? (w_tgt_ext - w_cnt_ext)
                                           : (w_tgt_ext + c_N - w_cnt_ext);
    assign w_dd = (w_cnt_ext >= w_tgt_ext) ? (w_cnt_ext - w_tgt_ext)
                                           : (w_cnt_ext + c_N - w_tgt_ext);

    assign w_step_val = r_up ? ((r_count == c_LAST) ? '0 : r_count + 1'b1)
                             : ((r_count == '0) ? c_LAST : r_count - 1'b1);

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        w_up_nxt     = r_up;
        w_err_nxt    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_tgt_ext >= c_N) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_target_nxt = target;
                        case (dir_mode)
                            2'b00:   w_up_nxt = 1'b1;
                            2'b01:   w_up_nxt = 1'b0;
                            default: w_up_nxt = (w_du <= w_dd);
                        endcase
                        w_state_nxt = (target == r_count) ? S_DONE : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_slot) begin
                    w_count_nxt = w_step_val;
                    if (w_step_val == r_target) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_up     <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
            r_up     <= w_up_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign count   = r_count;
    assign up      = r_up;
    assign step_en = (r_state == S_RUN) && w_slot;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_counter_sequencer                                         |
// | Description : Randomized scoreboard bench for counter_sequencer.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_counter_sequencer;

    localparam int N   = 10;
    localparam int DIV = 4;
    localparam int W   = $clog2(N);
`ifdef STEP_PRESCALE_EN
    localparam int P = DIV;
`else
    localparam int P = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] target;
    logic [1:0]   dir_mode;
    logic         abort;
    logic [W-1:0] count;
    logic         up;
    logic         step_en;
    logic         busy;
    logic         done;
    logic         err;

    counter_sequencer #(.N(N), .DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .target   (target),
        .dir_mode (dir_mode),
        .abort    (abort),
        .count    (count),
        .up       (up),
        .step_en  (step_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
        int up;
        int busy;
        int done;
        int err;
        int se;
        int chk_se;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  m_count  = 0;
    int  m_up     = 1;
    logic mon_en  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(int c, int cnt, int u, int b, int d, int e, int se, int cse);
        ev_t ev;
        ev.cyc = c; ev.cnt = cnt; ev.up = u; ev.busy = b;
        ev.done = d; ev.err = e; ev.se = se; ev.chk_se = cse;
        exp_q.push_back(ev);
    endfunction

    // Monitor: any count change or pulse is a DUT response and consumes one expectation.
    int   prev_count;
    logic prev_se, prev_abort, prev_rst, mon_init = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (mon_init) begin
                if (prev_se && prev_rst && !prev_abort)
                    chk("step_en_moves_count", int'(int'(count) != prev_count), 1);
                if (int'(count) != prev_count || done || err) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event_count", int'(count), prev_count);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        chk("ev_cycle", cyc, e.cyc);
                        chk("ev_count", int'(count), e.cnt);
                        chk("ev_up", int'(up), e.up);
                        chk("ev_busy", int'(busy), e.busy);
                        chk("ev_done", int'(done), e.done);
                        chk("ev_err", int'(err), e.err);
                        if (e.chk_se != 0) chk("ev_prev_step_en", int'(prev_se), e.se);
                    end
                end
            end
            mon_init   = 1'b1;
            prev_count = int'(count);
            prev_se    = step_en;
            prev_abort = abort;
            prev_rst   = rst;
        end
    end

    task automatic drive_junk();
        start    = 1'b1;
        target   = W'($urandom_range(0, 15));
        dir_mode = 2'($urandom_range(0, 3));
    endtask

    // kind: 0 complete run, 1 abort after k steps, 2 reset after k steps (k<0 picks randomly)
    task automatic do_txn(input int tgt, input int mode, input int kind_in, input int k_in, input bit junk);
        int acc, du, dd, d, k, kind, wait_n, steps;
        int upn;
        acc  = cyc + 1;
        kind = kind_in;
        k    = k_in;
        start    = 1'b1;
        target   = W'(tgt);
        dir_mode = 2'(mode);
        if (tgt >= N) begin
            push_ev(acc, m_count, m_up, 0, 0, 1, 0, 1);
            @(posedge clk); #1;
            start = 1'b0;
            return;
        end
        du  = (tgt - m_count + N) % N;
        dd  = (m_count - tgt + N) % N;
        upn = (mode == 0) ? 1 : (mode == 1) ? 0 : ((du <= dd) ? 1 : 0);
        d   = (upn != 0) ? du : dd;
        m_up = upn;
        if (d == 0) kind = 0;
        if (kind != 0 && (k < 0 || k >= d)) k = $urandom_range(0, d - 1);
        if (d == 0) begin
            push_ev(acc, m_count, m_up, 1, 1, 0, 0, 1);
        end else begin
            steps = (kind == 0) ? d : k;
            for (int j = 1; j <= steps; j++) begin
                m_count = (upn != 0) ? (m_count + 1) % N : (m_count + N - 1) % N;
                push_ev(acc + j * P, m_count, m_up, 1, (kind == 0 && j == d) ? 1 : 0, 0, 1, 1);
            end
            if (kind == 2 && m_count != 0) push_ev(acc + k * P + 1, 0, 1, 0, 0, 0, 0, 0);
        end
        @(posedge clk); #1;
        wait_n = (kind == 0) ? d * P + 1 : k * P;
        for (int i = 0; i < wait_n; i++) begin
            if (junk) drive_junk(); else start = 1'b0;
            if (kind == 0 && i == d * P && $urandom_range(0, 1) == 1) abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        start = 1'b0;
        if (kind == 1) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            chk("abort_busy", int'(busy), 0);
            chk("abort_count_held", int'(count), m_count);
            @(posedge clk); #1;
        end else if (kind == 2) begin
            rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            m_count = 0;
            m_up    = 1;
            @(negedge clk);
            chk("midrun_reset_busy", int'(busy), 0);
            chk("midrun_reset_count", int'(count), 0);
            chk("midrun_reset_up", int'(up), 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 2)) begin
            abort = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            abort = 1'b0;
        end
    endtask

    initial begin
        int r, tgt, kind;
        rst = 1'b0; start = 1'b0; target = '0; dir_mode = 2'b00; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_count", int'(count), 0);
        chk("reset_up", int'(up), 1);
        chk("reset_step_en", int'(step_en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        do_txn(3, 0, 0, 0, 0);   // 1,2,3 up
        do_txn(2, 1, 0, 0, 1);   // 3->2 down
        do_txn(8, 1, 0, 0, 0);   // 1,0,9,8
        do_txn(1, 0, 0, 0, 1);   // 9,0,1
        do_txn(8, 2, 0, 0, 0);   // shortest: down 0,9,8
        do_txn(0, 2, 0, 0, 0);   // shortest: up 9,0
        do_txn(5, 2, 0, 0, 0);   // tie goes up
        do_txn(12, 0, 0, 0, 0);  // rejected
        do_txn(5, 1, 0, 0, 0);   // zero-length
        do_txn(0, 3, 0, 0, 0);   // mode 11 tie from 5 goes up
        do_txn(7, 0, 1, 4, 0);   // abort at count 4
        do_txn(9, 0, 2, 2, 0);   // reset mid-run
        idle_gap();

        for (int t = 0; t < 60; t++) begin
            r    = $urandom_range(0, 99);
            tgt  = (r < 10) ? $urandom_range(N, 15) : $urandom_range(0, N - 1);
            kind = (r >= 10 && r < 22) ? 1 : (r >= 22 && r < 28) ? 2 : 0;
            do_txn(tgt, $urandom_range(0, 3), kind, -1, 1'($urandom_range(0, 1)));
            idle_gap();
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
